// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter (package arb_pkg).
// Helpers work on a fixed 16-bit container; callers slice out their N bits.
package arb_pkg;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

   localparam int ARB_N_DEFAULT = 4;
   localparam int ARB_N_MAX     = 16;

   function automatic logic [ARB_N_MAX-1:0] onehot(input logic [3:0] idx);
      logic [ARB_N_MAX-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Rotate the low n bits of vec right by sh; bits at and above n read as 0.
   function automatic logic [ARB_N_MAX-1:0] rotr(input logic [ARB_N_MAX-1:0] vec,
                                                 input logic [3:0] sh,
                                                 input int n);
      logic [ARB_N_MAX-1:0] r;
      int j;
      r = '0;
      for (int i = 0; i < ARB_N_MAX; i++) begin
         if (i < n) begin
            j    = (i + int'(sh)) % n;
            r[i] = vec[j[3:0]];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Lowest-index-first priority encoder; found flags any set bit.
module prio_enc_n #(
   parameter int N = 4
) (
   input  logic [N-1:0]         vec,
   output logic [$clog2(N)-1:0] idx,
   output logic                 found
);
   localparam int IDW = $clog2(N);

   // seen[i] is set when any bit below i is set, so only the first set bit is taken.
   logic [N:0] seen;

   assign seen[0] = 1'b0;
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_seen
         assign seen[gi+1] = seen[gi] | vec[gi];
      end
   endgenerate

   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i] && !seen[i]) idx = idx | IDW'(i);
      end
   end

   assign found = seen[N];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grant held until the owner drops req, then passed fairly onward.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles of ownership.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = ARB_N_DEFAULT,
   parameter int IDW      = $clog2(N),
   parameter int MAX_HOLD = 15
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid,
   output logic           timeout
);

   arb_state_t           state_reg, state_next;
   logic [N-1:0]         gnt_reg, gnt_next;
   logic [IDW-1:0]       gnt_id_reg, gnt_id_next;
   logic [IDW-1:0]       ptr_reg, ptr_next;
   logic [IDW-1:0]       ptr_inc, arb_ptr, enc_idx, winner;
   logic [IDW:0]         win_sum;
   logic                 owner_req, hold_expired, release_now, found, load;
   logic [ARB_N_MAX-1:0] rot_full, oh_full;
   logic [N-1:0]         req_rot;

   assign owner_req   = req[gnt_id_reg];
   assign ptr_inc     = (gnt_id_reg == IDW'(N-1)) ? '0 : gnt_id_reg + 1'b1;
   assign release_now = (state_reg == BUSY) && (!owner_req || hold_expired);
   // On a release the pointer has already moved past the old owner for this arbitration.
   assign arb_ptr     = release_now ? ptr_inc : ptr_reg;

   assign rot_full = rotr(ARB_N_MAX'(req), 4'(arb_ptr), N);
   assign req_rot  = rot_full[N-1:0];

   prio_enc_n #(.N(N)) u_enc (
      .vec   (req_rot),
      .idx   (enc_idx),
      .found (found)
   );

   assign win_sum = {1'b0, enc_idx} + {1'b0, arb_ptr};
   assign winner  = (win_sum >= (IDW+1)'(N)) ? IDW'(win_sum - (IDW+1)'(N)) : win_sum[IDW-1:0];
   assign oh_full = onehot(4'(winner));

   generate
      if (N < ARB_N_MAX) begin : g_pad
         logic unused_hi;
         assign unused_hi = ^{rot_full[ARB_N_MAX-1:N], oh_full[ARB_N_MAX-1:N]};
      end
   endgenerate

   always_comb begin
      state_next  = state_reg;
      gnt_next    = gnt_reg;
      gnt_id_next = gnt_id_reg;
      ptr_next    = ptr_reg;
      load        = 1'b0;
      case (state_reg)
         IDLE: load = found;
         BUSY: begin
            if (release_now) begin
               ptr_next = ptr_inc;
               load     = found;
               if (!found) begin
                  state_next  = IDLE;
                  gnt_next    = '0;
                  gnt_id_next = '0;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (load) begin
         state_next  = BUSY;
         gnt_next    = oh_full[N-1:0];
         gnt_id_next = winner;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         gnt_reg    <= '0;
         gnt_id_reg <= '0;
         ptr_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         gnt_reg    <= gnt_next;
         gnt_id_reg <= gnt_id_next;
         ptr_reg    <= ptr_next;
      end
   end

   assign gnt       = gnt_reg;
   assign gnt_id    = gnt_id_reg;
   assign gnt_valid = |gnt_reg;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD + 1);

   logic [CW-1:0] hold_reg;
   logic          timeout_reg;

   // hold_reg counts completed cycles of the current grant; the last allowed one revokes.
   assign hold_expired = owner_req && (hold_reg == CW'(MAX_HOLD - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_reg    <= '0;
         timeout_reg <= 1'b0;
      end else begin
         timeout_reg <= release_now && hold_expired;
         if (load)
            hold_reg <= '0;
         else if (state_reg == BUSY)
            hold_reg <= hold_reg + 1'b1;
      end
   end

   assign timeout = timeout_reg;
`else
   localparam int unused_max_hold = MAX_HOLD;

   assign hold_expired = 1'b0;
   assign timeout      = 1'b0;
`endif

endmodule
